// File: rtl/rans_mod_pkg.sv
// Shared types and defaults for the rANS modulo arbiter.
// State encoding and lane-pointer helper used by the arbiter FSM.
package rans_mod_pkg;

   localparam int W_DEF       = 64;
   localparam int TIMEOUT_DEF = 200;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } mod_arb_state_t;

   function automatic int ptr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting lane at or after the pointer.
// Produces a one-hot grant plus the binary index of the winner.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]  o_idx,
   output logic             o_any
);

   logic            w_hit_hi;
   logic            w_hit_lo;
   logic [ID_W-1:0] w_idx_hi;
   logic [ID_W-1:0] w_idx_lo;

   // Descending scan: the last hit written is the lowest index.
   always_comb begin
      w_hit_hi = 1'b0;
      w_hit_lo = 1'b0;
      w_idx_hi = '0;
      w_idx_lo = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (i_req[j]) begin
            w_hit_lo = 1'b1;
            w_idx_lo = ID_W'(j);
            if (ID_W'(j) >= i_ptr) begin
               w_hit_hi = 1'b1;
               w_idx_hi = ID_W'(j);
            end
         end
      end
   end

   assign o_any = w_hit_lo;
   assign o_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
   assign o_gnt = w_hit_lo ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/modulo_arbiter.sv
// Shares one modulo unit between N_REQ rANS lanes, round-robin.
// Sequences the unit reset/run/valid protocol and returns x mod z.
module modulo_arbiter
   import rans_mod_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int N_REQ   = 4,
   parameter int ID_W    = $clog2(N_REQ),
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_x,
   input  logic [N_REQ*W-1:0] req_z,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [W-1:0]       rsp_rem,
   output logic               rsp_zdiv,
   output logic               rsp_err,
   output logic               busy,
   output logic               mod_reset,
   output logic [W/2-1:0]     mod_x_high,
   output logic [W/2-1:0]     mod_x_low,
   output logic [W/2-1:0]     mod_z_high,
   output logic [W/2-1:0]     mod_z_low,
   input  logic               mod_valid_out,
   input  logic [W/2-1:0]     mod_res_high,
   input  logic [W/2-1:0]     mod_res_low
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   mod_arb_state_t r_state;
   mod_arb_state_t w_state_nxt;

   logic [ID_W-1:0]  r_rr_ptr;
   logic [ID_W-1:0]  r_id;
   logic [W-1:0]     r_x;
   logic [W-1:0]     r_z;
   logic [W-1:0]     r_rem;
   logic             r_zdiv;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic [N_REQ-1:0] w_gnt;
   logic [ID_W-1:0]  w_gidx;
   logic             w_any;
   logic [W-1:0]     w_sel_x;
   logic [W-1:0]     w_sel_z;
   logic             w_zero;
   logic             w_grant;
   logic             w_cap;
   logic             w_tmo;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gidx),
      .o_any (w_any)
   );

   always_comb begin
      w_sel_x = '0;
      w_sel_z = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gidx == ID_W'(i)) begin
            w_sel_x = req_x[i*W +: W];
            w_sel_z = req_z[i*W +: W];
         end
      end
   end

   assign w_zero  = (w_sel_z == '0);
   assign w_grant = (r_state == IDLE) && w_any;

   // First WAIT cycle may see a valid left over from the previous run.
   assign w_cap = (r_state == WAIT) && (r_cnt != '0) && mod_valid_out;
   assign w_tmo = (r_state == WAIT) && !w_cap
                  && (r_cnt == CNT_W'(TIMEOUT));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = w_zero ? RESP : LAUNCH;
            end
         end
         LAUNCH: w_state_nxt = WAIT;
         WAIT: begin
            if (w_cap || w_tmo) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_x      <= '0;
         r_z      <= '0;
         r_rem    <= '0;
         r_zdiv   <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_x      <= w_sel_x;
            r_z      <= w_sel_z;
            r_id     <= w_gidx;
            r_rr_ptr <= ID_W'(ptr_next(int'(w_gidx), N_REQ));
            if (w_zero) begin
               r_rem  <= w_sel_x;
               r_zdiv <= 1'b1;
            end
         end
         if (r_state == LAUNCH) begin
            r_cnt <= '0;
         end
         if (r_state == WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_cap) begin
            r_rem <= {mod_res_high, mod_res_low};
         end else if (w_tmo) begin
            r_rem <= '0;
            r_err <= 1'b1;
         end
         if ((r_state == RESP) && rsp_ready) begin
            r_zdiv <= 1'b0;
            r_err  <= 1'b0;
         end
      end
   end

   assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
   assign rsp_valid  = (r_state == RESP);
   assign rsp_id     = r_id;
   assign rsp_rem    = r_rem;
   assign rsp_zdiv   = r_zdiv;
   assign rsp_err    = r_err;
   assign busy       = (r_state != IDLE);
   assign mod_reset  = (r_state != WAIT);
   assign mod_x_high = r_x[W-1:W/2];
   assign mod_x_low  = r_x[W/2-1:0];
   assign mod_z_high = r_z[W-1:W/2];
   assign mod_z_low  = r_z[W/2-1:0];

endmodule

// File: tb/tb_modulo_arbiter.sv
// Directed bench for modulo_arbiter with a stub modulo unit.
// Stub modes: 0 = valid on 4th run cycle, 1 = never, 2 = stale valid.
module tb_modulo_arbiter;

   localparam int W     = 64;
   localparam int N     = 4;
   localparam int IDW   = 2;
   localparam int TMO   = 200;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_x;
   logic [N*W-1:0]   req_z;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [W-1:0]     rsp_rem;
   logic             rsp_zdiv;
   logic             rsp_err;
   logic             busy;
   logic             mod_reset;
   logic [W/2-1:0]   mod_x_high;
   logic [W/2-1:0]   mod_x_low;
   logic [W/2-1:0]   mod_z_high;
   logic [W/2-1:0]   mod_z_low;
   logic             mod_valid_out;
   logic [W/2-1:0]   mod_res_high;
   logic [W/2-1:0]   mod_res_low;

   int   checks = 0;
   int   errors = 0;
   int   stub_mode = 0;
   int   stub_cnt = 0;
   int   low_cnt = 0;
   logic [W-1:0] stub_x;
   logic [W-1:0] stub_z;
   logic [W-1:0] stub_res;

   modulo_arbiter #(
      .W(W), .N_REQ(N), .ID_W(IDW), .TIMEOUT(TMO)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_z(req_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_rem(rsp_rem),
      .rsp_zdiv(rsp_zdiv), .rsp_err(rsp_err), .busy(busy),
      .mod_reset(mod_reset),
      .mod_x_high(mod_x_high), .mod_x_low(mod_x_low),
      .mod_z_high(mod_z_high), .mod_z_low(mod_z_low),
      .mod_valid_out(mod_valid_out),
      .mod_res_high(mod_res_high), .mod_res_low(mod_res_low)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mod_reset) stub_cnt <= 0;
      else           stub_cnt <= stub_cnt + 1;
   end

   always @(negedge clock) begin
      if (!mod_reset) low_cnt <= low_cnt + 1;
   end

   always_comb begin
      stub_x = {mod_x_high, mod_x_low};
      stub_z = {mod_z_high, mod_z_low};
      stub_res = (stub_z != '0) ? stub_x % stub_z : '0;
      mod_valid_out = 1'b0;
      case (stub_mode)
         0: mod_valid_out = !mod_reset && (stub_cnt >= 3);
         2: begin
            mod_valid_out = 1'b1;
            if (stub_cnt == 0) stub_res = 64'hDEAD_BEEF_0BAD_F00D;
         end
         default: mod_valid_out = 1'b0;
      endcase
      {mod_res_high, mod_res_low} = stub_res;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_lane(input int l, input logic [W-1:0] x,
                           input logic [W-1:0] z);
      req_x[l*W +: W] = x;
      req_z[l*W +: W] = z;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic wait_rsp(output int n, output bit ok);
      n = 0;
      while (!rsp_valid && n < 400) begin
         step();
         n++;
      end
      ok = rsp_valid;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_x     = '0;
      req_z     = '0;
      #3;
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_zdiv, rsp_err} !== 8'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=0",
                  {req_ready, rsp_valid, busy, rsp_zdiv, rsp_err});
      end
      checks++;
      if (rsp_id !== 2'd0 || rsp_rem !== 64'd0) begin
         errors++;
         $display("FAIL reset_rsp id=%0d rem=%0d exp 0/0", rsp_id, rsp_rem);
      end
      checks++;
      if (mod_reset !== 1'b1 || {mod_x_high, mod_x_low, mod_z_high,
                                 mod_z_low} !== 128'd0) begin
         errors++;
         $display("FAIL reset_mod mod_reset=%b exp=1 operands nonzero",
                  mod_reset);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int n;
      bit ok;
      stub_mode = 0;
      set_lane(2, 64'd100, 64'd7);
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL t1_grant got=%b exp=0100", req_ready);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0000 || mod_reset !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL t1_launch ready=%b mod_reset=%b busy=%b exp 0/1/1",
                  req_ready, mod_reset, busy);
      end
      wait_rsp(n, ok);
      checks++;
      if (!ok || n + 1 != 6) begin
         errors++;
         $display("FAIL t1_latency got=%0d exp=6 ok=%0d", n + 1, ok);
      end
      checks++;
      if (rsp_id !== 2'd2 || rsp_rem !== 64'd2 || rsp_zdiv !== 1'b0
          || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL t1_rsp id=%0d rem=%0d z=%b e=%b exp 2/2/0/0",
                  rsp_id, rsp_rem, rsp_zdiv, rsp_err);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t1_accept valid=%b busy=%b exp 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_fairness();
      int n;
      bit ok;
      logic [IDW-1:0] exp_id [5];
      logic [W-1:0]   exp_rem [5];
      exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_rem = '{64'd1, 64'd2, 64'd0, 64'd1, 64'd1};
      do_reset();
      stub_mode = 0;
      for (int i = 0; i < N; i++) set_lane(i, 64'(10 + i), 64'd3);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(n, ok);
         checks++;
         if (!ok || rsp_id !== exp_id[k] || rsp_rem !== exp_rem[k]) begin
            errors++;
            $display("FAIL t2_rr[%0d] id=%0d rem=%0d exp %0d/%0d ok=%0d",
                     k, rsp_id, rsp_rem, exp_id[k], exp_rem[k], ok);
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
   endtask

   task automatic test_zdiv();
      int n;
      bit ok;
      int low0;
      set_lane(1, 64'd55, 64'd0);
      req_valid = 4'b0010;
      low0 = low_cnt;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL t3_grant got=%b exp=0010", req_ready);
      end
      step();
      req_valid = '0;
      wait_rsp(n, ok);
      checks++;
      if (!ok || n != 0) begin
         errors++;
         $display("FAIL t3_latency got=%0d exp=1 ok=%0d", n + 1, ok);
      end
      checks++;
      if (rsp_id !== 2'd1 || rsp_rem !== 64'd55 || rsp_zdiv !== 1'b1
          || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL t3_rsp id=%0d rem=%0d z=%b e=%b exp 1/55/1/0",
                  rsp_id, rsp_rem, rsp_zdiv, rsp_err);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      step();
      checks++;
      if (low_cnt != low0 || rsp_zdiv !== 1'b0) begin
         errors++;
         $display("FAIL t3_unit_idle low_cycles=%0d exp=0 zdiv=%b exp=0",
                  low_cnt - low0, rsp_zdiv);
      end
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      int low0;
      stub_mode = 1;
      set_lane(0, 64'd9, 64'd4);
      req_valid = 4'b0001;
      low0 = low_cnt;
      step();
      req_valid = '0;
      wait_rsp(n, ok);
      checks++;
      if (!ok || low_cnt - low0 != TMO + 1) begin
         errors++;
         $display("FAIL t4_wait_cycles got=%0d exp=%0d ok=%0d",
                  low_cnt - low0, TMO + 1, ok);
      end
      checks++;
      if (rsp_err !== 1'b1 || rsp_rem !== 64'd0 || rsp_zdiv !== 1'b0
          || rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL t4_rsp e=%b rem=%0d z=%b id=%0d exp 1/0/0/0",
                  rsp_err, rsp_rem, rsp_zdiv, rsp_id);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t4_clear err=%b busy=%b exp 0/0", rsp_err, busy);
      end
      stub_mode = 0;
   endtask

   task automatic test_backpressure();
      int n;
      bit ok;
      int bad;
      stub_mode = 0;
      set_lane(3, 64'h0000_0100_0000_0005, 64'h0000_0000_0010_0000);
      set_lane(0, 64'd1, 64'd1);
      req_valid = 4'b1000;
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL t5_grant got=%b exp=1000", req_ready);
      end
      step();
      req_valid = 4'b0001;
      wait_rsp(n, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL t5_rsp_timeout got=0 exp=1");
      end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_rem !== 64'd5
             || req_ready !== 4'b0000 || rsp_err !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t5_stall unstable_cycles=%0d exp=0 rem=%0d id=%0d",
                  bad, rsp_rem, rsp_id);
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL t5_no_grant_hs got=%b exp=0000", req_ready);
      end
      step();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL t5_next_grant got=%b exp=0001", req_ready);
      end
      step();
      req_valid = '0;
      wait_rsp(n, ok);
      checks++;
      if (!ok || rsp_id !== 2'd0 || rsp_rem !== 64'd0) begin
         errors++;
         $display("FAIL t5_next_rsp id=%0d rem=%0d exp 0/0 ok=%0d",
                  rsp_id, rsp_rem, ok);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_stale_guard();
      int n;
      bit ok;
      stub_mode = 2;
      set_lane(1, 64'd100, 64'd7);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      wait_rsp(n, ok);
      checks++;
      if (!ok || n + 1 != 4 || rsp_rem !== 64'd2) begin
         errors++;
         $display("FAIL t7_stale lat=%0d exp=4 rem=%0h exp=2 ok=%0d",
                  n + 1, rsp_rem, ok);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      stub_mode = 0;
   endtask

   task automatic test_reset_mid_wait();
      int n;
      bit ok;
      stub_mode = 0;
      set_lane(2, 64'd100, 64'd7);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step();
      #1;
      checks++;
      if (mod_reset !== 1'b0) begin
         errors++;
         $display("FAIL t6_in_wait mod_reset=%b exp=0", mod_reset);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || mod_reset !== 1'b1) begin
         errors++;
         $display("FAIL t6_abort valid=%b busy=%b mod_reset=%b exp 0/0/1",
                  rsp_valid, busy, mod_reset);
      end
      step();
      reset_n = 1'b1;
      step();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t6_no_rsp valid=%b busy=%b exp 0/0", rsp_valid, busy);
      end
      set_lane(1, 64'd20, 64'd6);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      wait_rsp(n, ok);
      checks++;
      if (!ok || n + 1 != 6 || rsp_id !== 2'd1 || rsp_rem !== 64'd2) begin
         errors++;
         $display("FAIL t6_after lat=%0d id=%0d rem=%0d exp 6/1/2 ok=%0d",
                  n + 1, rsp_id, rsp_rem, ok);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_zdiv();
      test_timeout();
      test_backpressure();
      test_stale_guard();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
